// File: rtl/round_saturate_pipe.sv
// Multi-lane rounding and saturation stage with a two-deep valid/ready pipeline.
// Stage 1 holds the rounded value per lane. Stage 2 holds the clamped output and the saturation flags.
module round_saturate_pipe #(
    parameter int WIDTH_IN  = 19,
    parameter int WIDTH_OUT = 16,
    parameter int SHIFT     = 3,
    parameter int IS_SIGNED = 1,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [CHANNELS*WIDTH_IN-1:0]  i_data,
    input  logic [1:0]                    i_mode,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [CHANNELS*WIDTH_OUT-1:0] o_data,
    output logic [CHANNELS-1:0]           o_sat,
    input  logic                          i_clr_count,
    output logic [CNT_WIDTH-1:0]          o_sat_count
);

    // One extra bit keeps the carry out of the round-up increment.
    localparam int RW  = WIDTH_IN - SHIFT + 1;
    localparam bit SGN = (IS_SIGNED != 0);

    if (WIDTH_IN < 1 || SHIFT < 0 || SHIFT >= WIDTH_IN || WIDTH_OUT < 1 ||
        WIDTH_OUT > WIDTH_IN - SHIFT || CHANNELS < 1 || CNT_WIDTH < 1) begin : g_param_err
        $error("round_saturate_pipe: illegal parameter combination");
    end

    logic                          en1;
    logic                          en2;
    logic                          s1_valid_reg;
    logic                          o_valid_reg;
    logic [RW-1:0]                 r_next   [CHANNELS];
    logic [RW-1:0]                 s1_r_reg [CHANNELS];
    logic [CHANNELS*WIDTH_OUT-1:0] sat_data;
    logic [CHANNELS*WIDTH_OUT-1:0] o_data_reg;
    logic [CHANNELS-1:0]           sat_flag;
    logic [CHANNELS-1:0]           o_sat_reg;
    logic [CNT_WIDTH-1:0]          cnt_reg;

    assign en2     = !o_valid_reg || i_ready;
    assign en1     = !s1_valid_reg || en2;
    assign o_ready = en1 && !i_rst;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        logic [WIDTH_IN-1:0]  lane_in;
        logic                 ext;
        logic [RW-1:0]        r_q;
        logic                 ovf;
        logic [WIDTH_OUT-1:0] clamp;

        assign lane_in = i_data[gi*WIDTH_IN +: WIDTH_IN];
        assign ext     = SGN && lane_in[WIDTH_IN-1];

        if (SHIFT == 0) begin : g_noround
            assign r_next[gi] = {ext, lane_in};
        end else begin : g_round
            localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
            logic [SHIFT-1:0] frac;
            logic             up;

            assign frac = lane_in[SHIFT-1:0];

            always_comb begin
                up = 1'b0;
                case (i_mode)
                    2'd1:    up = (frac >= HALF);
                    2'd2:    up = (frac > HALF) || ((frac == HALF) && lane_in[SHIFT]);
                    2'd3:    up = (frac > HALF) || ((frac == HALF) && !ext);
                    default: up = 1'b0;
                endcase
            end

            assign r_next[gi] = {ext, lane_in[WIDTH_IN-1:SHIFT]} + RW'(up);
        end

        assign r_q = s1_r_reg[gi];

        if (SGN) begin : g_ssat
            localparam logic [WIDTH_OUT-1:0] SMIN = WIDTH_OUT'(1) << (WIDTH_OUT - 1);
            logic [RW-WIDTH_OUT:0] top;

            // The value fits only when every bit above the output sign bit copies it.
            assign top   = r_q[RW-1:WIDTH_OUT-1];
            assign ovf   = !((&top) || !(|top));
            assign clamp = r_q[RW-1] ? SMIN : ~SMIN;
        end else begin : g_usat
            assign ovf   = |r_q[RW-1:WIDTH_OUT];
            assign clamp = '1;
        end

        assign sat_data[gi*WIDTH_OUT +: WIDTH_OUT] = ovf ? clamp : r_q[WIDTH_OUT-1:0];
        assign sat_flag[gi]                        = ovf;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_reg <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                s1_r_reg[k] <= '0;
            end
        end else if (en1) begin
            s1_valid_reg <= i_valid;
            if (i_valid) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    s1_r_reg[k] <= r_next[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
            o_sat_reg   <= '0;
        end else if (en2) begin
            o_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                o_data_reg <= sat_data;
                o_sat_reg  <= sat_flag;
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_count) begin
            cnt_reg <= '0;
        end else if (o_valid_reg && i_ready && (|o_sat_reg) && !(&cnt_reg)) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign o_valid     = o_valid_reg;
    assign o_data      = o_data_reg;
    assign o_sat       = o_sat_reg;
    assign o_sat_count = cnt_reg;

endmodule

// File: tb/tb_round_saturate_pipe.sv
// Directed bench for round_saturate_pipe: a signed and an unsigned instance share one stimulus bus.
// Expected values are hand computed for WIDTH_IN=8, SHIFT=2, WIDTH_OUT=5, CHANNELS=2, CNT_WIDTH=2.
module tb_round_saturate_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       ready_in;
    logic       clr;
    logic [15:0] data;
    logic [1:0] mode;

    logic       s_ordy, s_ovalid, u_ordy, u_ovalid;
    logic [9:0] s_odata, u_odata;
    logic [1:0] s_osat, u_osat, s_cnt, u_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    round_saturate_pipe #(
        .WIDTH_IN(8), .WIDTH_OUT(5), .SHIFT(2), .IS_SIGNED(1), .CHANNELS(2), .CNT_WIDTH(2)
    ) dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(s_ordy), .i_data(data),
        .i_mode(mode), .o_valid(s_ovalid), .i_ready(ready_in), .o_data(s_odata),
        .o_sat(s_osat), .i_clr_count(clr), .o_sat_count(s_cnt)
    );

    round_saturate_pipe #(
        .WIDTH_IN(8), .WIDTH_OUT(5), .SHIFT(2), .IS_SIGNED(0), .CHANNELS(2), .CNT_WIDTH(2)
    ) dut_u (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(u_ordy), .i_data(data),
        .i_mode(mode), .o_valid(u_ovalid), .i_ready(ready_in), .o_data(u_odata),
        .o_sat(u_osat), .i_clr_count(clr), .o_sat_count(u_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] l5(input int v);
        logic [4:0] t;
        t = v[4:0];
        return {27'd0, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Mode is scrambled right after acceptance; the beat must keep its own rounding.
    task automatic push(input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] m);
        valid = 1'b1;
        data  = {d1, d0};
        mode  = m;
        #1;
        check("push_rdy", {31'd0, s_ordy}, 32'd1);
        tick();
        valid = 1'b0;
        mode  = ~m;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!s_ovalid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, s_ovalid}, 32'd1);
    endtask

    task automatic expect_out(input string tag, input bit uns, input int e0, input int e1,
                              input logic [1:0] es);
        wait_valid(tag);
        check({tag, "_l0"},  {27'd0, uns ? u_odata[4:0] : s_odata[4:0]}, l5(e0));
        check({tag, "_l1"},  {27'd0, uns ? u_odata[9:5] : s_odata[9:5]}, l5(e1));
        check({tag, "_sat"}, {30'd0, uns ? u_osat : s_osat}, {30'd0, es});
        $display("[TB] %s lanes %0d/%0d sat %b", tag, e0, e1, es);
        tick();
    endtask

    int  e0_tab [4] = '{2, 3, 2, 3};
    int  e1_tab [4] = '{-3, -2, -2, -3};
    int  sent;
    int  recv;
    bit  in_hs;
    bit  stall;

    initial begin
        rst      = 1'b1;
        valid    = 1'b0;
        ready_in = 1'b1;
        clr      = 1'b0;
        data     = '0;
        mode     = 2'd0;
        @(negedge clk);
        repeat (2) tick();
        check("rst_ovalid", {31'd0, s_ovalid}, 32'd0);
        check("rst_odata",  {22'd0, s_odata}, 32'd0);
        check("rst_osat",   {30'd0, s_osat}, 32'd0);
        check("rst_cnt",    {30'd0, s_cnt}, 32'd0);
        check("rst_ordy",   {31'd0, s_ordy}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ordy", {31'd0, s_ordy}, 32'd1);

        for (int m = 0; m < 4; m++) begin
            push(8'h0A, 8'hF6, 2'(m));
            expect_out($sformatf("mode%0d", m), 1'b0, e0_tab[m], e1_tab[m], 2'b00);
        end
        push(8'h0E, 8'hF6, 2'd2);
        expect_out("even_3p5", 1'b0, 4, -2, 2'b00);

        push(8'h7F, 8'h80, 2'd0);
        expect_out("sat_max_min", 1'b0, 15, -16, 2'b11);
        push(8'h3E, 8'hBF, 2'd1);
        expect_out("carry_m1", 1'b0, 15, -16, 2'b01);
        push(8'h3E, 8'hBF, 2'd0);
        expect_out("floor_m0", 1'b0, 15, -16, 2'b10);

        push(8'hFF, 8'h7E, 2'd1);
        expect_out("uns_ff_7e", 1'b1, 31, 31, 2'b11);
        push(8'h7D, 8'h00, 2'd1);
        expect_out("uns_7d", 1'b1, 31, 0, 2'b00);

        // Eight beats, lane0 = 4k and lane1 = -4k, with i_ready low for cycles 3-6.
        sent = 0;
        recv = 0;
        for (int c = 0; c < 20; c++) begin
            stall    = (c >= 3 && c <= 6);
            valid    = (sent < 8);
            data     = {8'(-4 * (sent + 1)), 8'(4 * (sent + 1))};
            mode     = 2'd0;
            ready_in = !stall;
            #1;
            if (sent < 8)
                check($sformatf("bp_rdy_c%0d", c), {31'd0, s_ordy}, stall ? 32'd0 : 32'd1);
            if (stall)
                check($sformatf("bp_hold_valid_c%0d", c), {31'd0, s_ovalid}, 32'd1);
            if (s_ovalid) begin
                if (recv < 8) begin
                    check($sformatf("bp_l0_c%0d", c), {27'd0, s_odata[4:0]}, l5(recv + 1));
                    check($sformatf("bp_l1_c%0d", c), {27'd0, s_odata[9:5]}, l5(-(recv + 1)));
                end else begin
                    check("bp_extra_beat", {31'd0, s_ovalid}, 32'd0);
                end
                if (ready_in) begin
                    $display("[TB] bp cycle %0d delivered beat %0d", c, recv + 1);
                    recv++;
                end
            end
            in_hs = valid && s_ordy;
            @(posedge clk);
            if (in_hs) sent++;
            @(negedge clk);
        end
        valid    = 1'b0;
        ready_in = 1'b1;
        check("bp_sent", sent, 32'd8);
        check("bp_recv", recv, 32'd8);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("cnt_cleared", {30'd0, s_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = {8'h80, 8'h7F};
            mode  = 2'd0;
            tick();
        end
        valid = 1'b0;
        repeat (3) tick();
        check("cnt_sticky", {30'd0, s_cnt}, 32'd3);
        $display("[TB] five saturating beats, count %0d", s_cnt);

        push(8'h7F, 8'h80, 2'd0);
        wait_valid("clr_at_max");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("cnt_clr_at_max", {30'd0, s_cnt}, 32'd0);
        push(8'h7F, 8'h80, 2'd0);
        expect_out("cnt_inc", 1'b0, 15, -16, 2'b11);
        check("cnt_one", {30'd0, s_cnt}, 32'd1);
        push(8'h7F, 8'h80, 2'd0);
        wait_valid("clr_wins");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("cnt_clr_wins", {30'd0, s_cnt}, 32'd0);

        // Three saturating beats back to back: first delivered, two left in flight.
        valid = 1'b1;
        data  = {8'h80, 8'h7F};
        mode  = 2'd0;
        repeat (3) tick();
        check("rst_pre_cnt",    {30'd0, s_cnt}, 32'd1);
        check("rst_pre_ovalid", {31'd0, s_ovalid}, 32'd1);
        rst  = 1'b1;
        data = {8'h04, 8'h04};
        #1;
        check("rst_mid_ordy", {31'd0, s_ordy}, 32'd0);
        tick();
        check("rst_mid_ovalid", {31'd0, s_ovalid}, 32'd0);
        check("rst_mid_odata",  {22'd0, s_odata}, 32'd0);
        check("rst_mid_osat",   {30'd0, s_osat}, 32'd0);
        check("rst_mid_cnt",    {30'd0, s_cnt}, 32'd0);
        check("rst_mid_ordy2",  {31'd0, s_ordy}, 32'd0);
        rst  = 1'b0;
        data = {8'hF6, 8'h0A};
        mode = 2'd0;
        #1;
        check("rst_rel_ordy", {31'd0, s_ordy}, 32'd1);
        tick();
        valid = 1'b0;
        check("rst_lat_early", {31'd0, s_ovalid}, 32'd0);
        tick();
        check("rst_lat_valid", {31'd0, s_ovalid}, 32'd1);
        check("rst_lat_l0",    {27'd0, s_odata[4:0]}, l5(2));
        check("rst_lat_l1",    {27'd0, s_odata[9:5]}, l5(-3));
        check("rst_lat_sat",   {30'd0, s_osat}, 32'd0);
        $display("[TB] first beat after reset lanes %0d/%0d", s_odata[4:0], s_odata[9:5]);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rst_no_stale_%0d", i), {31'd0, s_ovalid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
